fft_adc_loader: RTL and testbench
=================================

// Module: fft_adc_loader
// PURPOSE
//  Input stage in front of fft_top: captures a frame of N ADC samples from a valid-qualified stream.
//  Writes them into the four radix-4 RAM banks: bank0 gets samples 0..N/4-1, bank1 the next N/4, and so on.
//  Pulses fft_top's iSTART, then waits for oRDY before capturing the next frame.
//  Replaces the bench-driven bank fill with synthesizable RTL.
// PARAMETERS
//  N      4096  FFT length in points; must be a power of 4.
//  A_BIT  10    Bank address width, equal to log2(N/4).
//  D_BIT  16    fft_top data width; the ADC sample is D_BIT-1 bits (no bit expansion).
// PORTS
//  iCLK           in   1          system clock
//  iRESET         in   1          synchronous reset, active-high
//  iENABLE        in   1          arm capture; low aborts a fill in progress
//  iADC_DATA      in   D_BIT-1    signed ADC sample
//  iADC_VALID     in   1          sample qualifier, one sample per cycle max
//  iFFT_RDY       in   1          fft_top oRDY
//  oDATA          out  D_BIT-1    to fft_top iDATA, shared by all banks
//  oADDR_WR_0..3  out  A_BIT      to fft_top iADDR_WR_0..3
//  oWE_0..3       out  1          to fft_top iWE_0..3; at most one high per cycle
//  oSTART         out  1          to fft_top iSTART; one-cycle pulse
//  oBUSY          out  1          high in any state other than IDLE
//  oFRAME_DONE    out  1          one-cycle pulse when the FFT finishes a frame
//  oOVERRUN       out  1          sticky: a valid sample was dropped
// BEHAVIOUR
//  Reset: all outputs are 0, state is IDLE, sample counter cnt = 0. RAM contents are not touched.
//  Counter: cnt is log2(N) bits wide. Bank select = cnt[A_BIT+1:A_BIT]; address = cnt[A_BIT-1:0].
//  FSM states: IDLE, FILL, LAUNCH, WAIT_FFT.
//   IDLE -> FILL: when iENABLE=1. cnt is cleared and oOVERRUN is cleared on this transition.
//   FILL: on each cycle with iADC_VALID=1, the sample is registered.
//    On the next cycle, oDATA = sample, oADDR_WR_b = cnt[A_BIT-1:0], and oWE_b = 1 for the selected bank b only.
//    Latency is 1 cycle; cnt increments.
//    Cycles with iADC_VALID=0 produce no write and hold cnt.
//   FILL -> LAUNCH: after the sample with cnt = N-1 is accepted. cnt wraps to 0.
//   LAUNCH: lasts one cycle and is entered the cycle after the last oWE. oSTART = 1 in this cycle, then -> WAIT_FFT.
//    This guarantees the last RAM write completes before iSTART.
//   WAIT_FFT: ignores the iFFT_RDY level; waits for a 0->1 edge of iFFT_RDY.
//    The edge detector is cleared in LAUNCH, so a stale RDY high does not count.
//    On the edge: oFRAME_DONE = 1 for one cycle, then -> IDLE.
//  Overrun: iADC_VALID=1 in LAUNCH or WAIT_FFT drops the sample and sets oOVERRUN.
//   oOVERRUN stays set until reset or the next IDLE->FILL transition. Samples in IDLE are ignored silently.
//  Abort: iENABLE=0 during FILL -> IDLE next cycle. No oSTART is issued, cnt is cleared, and the partial frame is discarded.
//   iENABLE=0 in LAUNCH or WAIT_FFT has no effect; the frame completes.
//  Reset mid-operation: reset wins over every event. Any oWE or oSTART that would be issued in that cycle is suppressed.
//  Held outputs: oDATA and oADDR_WR hold their last value when no oWE is active.
// CONFIGURATION
//  FFT_LOADER_CONT_EN defined:
//   WAIT_FFT goes directly to FILL on the RDY edge if iENABLE=1; otherwise it goes to IDLE.
//   oOVERRUN is not cleared on this re-arm. It is cleared only via IDLE->FILL or reset.
//  FFT_LOADER_CONT_EN undefined:
//   The block always returns to IDLE. iENABLE must be high in IDLE to capture another frame.
// TESTING
//  1. Reset, then iENABLE=1 and 4096 back-to-back valid samples 0..4095.
//     -> Sample k is written to bank k/1024 at address k%1024.
//     -> oSTART pulses exactly 1 cycle after the last oWE.
//     -> fft_top RAM_A matches the ramp.
//  2. Valid asserted every 3rd cycle with constant 100.
//     -> Exactly 4096 writes, all with value 100; oSTART comes after the 4096th write only.
//  3. iFFT_RDY held high throughout LAUNCH, then low for 50 cycles, then high.
//     -> oFRAME_DONE pulses once, one cycle after the rise; oBUSY falls in the same cycle.
//  4. 10 valid samples during WAIT_FFT.
//     -> No oWE, oOVERRUN=1.
//     -> oOVERRUN clears on the next IDLE->FILL transition.
//  5. iENABLE dropped after 2000 samples.
//     -> IDLE, no oSTART.
//     -> On re-enable, the first sample goes to bank0 at address 0.
//  6. iRESET asserted at cnt=3000, and separately in the LAUNCH cycle.
//     -> All outputs 0 on the next cycle; no oSTART is issued.
//     -> With FFT_LOADER_CONT_EN and iENABLE held high, two consecutive frames complete with no IDLE cycle between them.

Source files
------------

// File: rtl/fft_adc_loader_if.sv
// fft_adc_loader_if: ADC stream in, fft_top bank-write/start/status out.
// master = stream source / fft side (bench); slave = the loader itself.
interface fft_adc_loader_if #(
  parameter int A_BIT = 10,
  parameter int D_BIT = 16
);

  logic             iENABLE;
  logic [D_BIT-2:0] iADC_DATA;
  logic             iADC_VALID;
  logic             iFFT_RDY;

  logic [D_BIT-2:0] oDATA;
  logic [A_BIT-1:0] oADDR_WR_0;
  logic [A_BIT-1:0] oADDR_WR_1;
  logic [A_BIT-1:0] oADDR_WR_2;
  logic [A_BIT-1:0] oADDR_WR_3;
  logic             oWE_0;
  logic             oWE_1;
  logic             oWE_2;
  logic             oWE_3;
  logic             oSTART;
  logic             oBUSY;
  logic             oFRAME_DONE;
  logic             oOVERRUN;

  modport master (
    output iENABLE, iADC_DATA, iADC_VALID, iFFT_RDY,
    input  oDATA,
    input  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    input  oWE_0, oWE_1, oWE_2, oWE_3,
    input  oSTART, oBUSY, oFRAME_DONE, oOVERRUN
  );

  modport slave (
    input  iENABLE, iADC_DATA, iADC_VALID, iFFT_RDY,
    output oDATA,
    output oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3,
    output oWE_0, oWE_1, oWE_2, oWE_3,
    output oSTART, oBUSY, oFRAME_DONE, oOVERRUN
  );

endinterface

// File: rtl/fft_adc_loader.sv
// fft_adc_loader: captures an N-sample ADC frame into the four
// radix-4 banks of fft_top, pulses START, waits for the RDY rise.
// Ports: iCLK, iRESET (sync, active-high); bus = slave modport of
//   fft_adc_loader_if (ADC stream, iENABLE, iFFT_RDY in; bank
//   data/addr/we, oSTART, oBUSY, oFRAME_DONE, oOVERRUN out).
// Option FFT_LOADER_CONT_EN: WAIT_FFT re-arms straight into FILL
//   when iENABLE is high instead of returning to IDLE.
module fft_adc_loader #(
  parameter int N     = 4096,
  parameter int A_BIT = 10,
  parameter int D_BIT = 16
) (
  input logic             iCLK,
  input logic             iRESET,
  fft_adc_loader_if.slave bus
);

  localparam int C_BIT = A_BIT + 2;
  localparam logic [C_BIT-1:0] LAST = C_BIT'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    LAUNCH,
    WAIT_FFT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [C_BIT-1:0] cnt;
  logic [1:0]       bank;
  logic             rdy_q;
  logic             rise;

  logic             acc;
  logic             drop;
  logic             arm;
  logic             cnt_clr;

  logic [D_BIT-2:0] data_q;
  logic [A_BIT-1:0] addr_q [4];
  logic [3:0]       we_q;
  logic             start_q;
  logic             done_q;
  logic             ovr_q;

  assign bank = cnt[A_BIT+1:A_BIT];

  // rdy_q tracks the RDY level every cycle, so a level that is
  // already high while in LAUNCH can never look like a rise.
  assign rise = bus.iFFT_RDY & ~rdy_q;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    acc      = 1'b0;
    drop     = 1'b0;
    arm      = 1'b0;
    cnt_clr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.iENABLE) begin
          state_nx = FILL;
          arm      = 1'b1;
          cnt_clr  = 1'b1;
        end
      end
      FILL: begin
        // abort beats a sample arriving in the same cycle
        if (!bus.iENABLE) begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end else if (bus.iADC_VALID) begin
          acc = 1'b1;
          if (cnt == LAST) begin
            state_nx = LAUNCH;
          end
        end
      end
      LAUNCH: begin
        drop     = bus.iADC_VALID;
        state_nx = WAIT_FFT;
      end
      WAIT_FFT: begin
        drop = bus.iADC_VALID;
        if (rise) begin
`ifdef FFT_LOADER_CONT_EN
          // cnt already wrapped to 0 on the last sample
          state_nx = bus.iENABLE ? FILL : IDLE;
`else
          state_nx = IDLE;
`endif
        end
      end
    endcase
  end

  // Registered outputs: the bank write for a sample appears one
  // cycle after it is accepted; START is registered from LAUNCH,
  // so it lands the cycle after the final write.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      cnt     <= '0;
      rdy_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '{default: '0};
      we_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rdy_q   <= bus.iFFT_RDY;
      we_q    <= '0;
      start_q <= (state == LAUNCH);
      done_q  <= (state == WAIT_FFT) && rise;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (acc) begin
        cnt <= cnt + C_BIT'(1);
      end
      if (arm) begin
        ovr_q <= 1'b0;
      end else if (drop) begin
        ovr_q <= 1'b1;
      end
      if (acc) begin
        data_q       <= bus.iADC_DATA;
        addr_q[bank] <= cnt[A_BIT-1:0];
        we_q[bank]   <= 1'b1;
      end
    end
  end

  assign bus.oDATA       = data_q;
  assign bus.oADDR_WR_0  = addr_q[0];
  assign bus.oADDR_WR_1  = addr_q[1];
  assign bus.oADDR_WR_2  = addr_q[2];
  assign bus.oADDR_WR_3  = addr_q[3];
  assign bus.oWE_0       = we_q[0];
  assign bus.oWE_1       = we_q[1];
  assign bus.oWE_2       = we_q[2];
  assign bus.oWE_3       = we_q[3];
  assign bus.oSTART      = start_q;
  assign bus.oBUSY       = (state != IDLE);
  assign bus.oFRAME_DONE = done_q;
  assign bus.oOVERRUN    = ovr_q;

endmodule

// File: tb/tb_fft_adc_loader.sv
// tb_fft_adc_loader: directed sequence with random samples/gaps;
// expected bank contents come from sample order k -> (k/Q, k%Q).
module tb_fft_adc_loader;

  localparam int N = 4096;
  localparam int A = 10;
  localparam int D = 16;
  localparam int Q = N / 4;
`ifdef FFT_LOADER_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    int           bank;
    int           addr;
    logic [D-2:0] data;
    int           cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fft_adc_loader_if #(.A_BIT(A), .D_BIT(D)) b ();

  fft_adc_loader #(
    .N     (N),
    .A_BIT (A),
    .D_BIT (D)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst),
    .bus    (b)
  );

  int           total = 0;
  int           bad   = 0;
  int           cyc   = 0;
  int           multi = 0;
  wr_t          wq [$];
  int           sq [$];
  int           dq [$];
  logic         dbz [$];
  logic [D-2:0] expq [$];
  logic [3:0]   wev;
  int           m_bi;
  logic [A-1:0] m_ad;

  // observer: logs every bank write, START and FRAME_DONE
  always @(posedge clk) begin
    #2;
    cyc = cyc + 1;
    wev = {b.oWE_3, b.oWE_2, b.oWE_1, b.oWE_0};
    if (wev != 4'b0) begin
      if ($countones(wev) != 1) multi = multi + 1;
      m_bi = wev[0] ? 0 : wev[1] ? 1 : wev[2] ? 2 : 3;
      m_ad = (m_bi == 0) ? b.oADDR_WR_0 :
             (m_bi == 1) ? b.oADDR_WR_1 :
             (m_bi == 2) ? b.oADDR_WR_2 : b.oADDR_WR_3;
      wq.push_back('{m_bi, int'(m_ad), b.oDATA, cyc});
    end
    if (b.oSTART) sq.push_back(cyc);
    if (b.oFRAME_DONE) begin
      dq.push_back(cyc);
      dbz.push_back(b.oBUSY);
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 0: ramp k, 1: constant cval, 2: random
  task automatic feed(int n, int gap, bit rgap, int mode,
                      logic [D-2:0] cval);
    int g;
    for (int k = 0; k < n; k++) begin
      g = rgap ? int'($urandom_range(2, 0)) : gap;
      b.iADC_VALID = 1'b0;
      repeat (g) @(negedge clk);
      case (mode)
        0:       b.iADC_DATA = (D-1)'(k);
        1:       b.iADC_DATA = cval;
        default: b.iADC_DATA = (D-1)'($urandom);
      endcase
      b.iADC_VALID = 1'b1;
      expq.push_back(b.iADC_DATA);
      @(negedge clk);
    end
    b.iADC_VALID = 1'b0;
  endtask

  task automatic wait_start(int sb);
    for (int i = 0; i < 8 && sq.size() == sb; i++) @(negedge clk);
  endtask

  task automatic check_frame(string p, int wb, int sb);
    logic [D-2:0] m [N];
    int last;
    int st;
    for (int k = 0; k < N; k++) m[k] = 'x;
    for (int i = wb; i < wq.size(); i++)
      m[wq[i].bank * Q + wq[i].addr] = wq[i].data;
    chk({p, "_we_count"}, 64'(wq.size() - wb), 64'(N));
    chk({p, "_start_count"}, 64'(sq.size() - sb), 64'd1);
    last = (wq.size() > wb) ? wq[$].cyc : -100;
    st   = (sq.size() > sb) ? sq[sb] : -1;
    chk({p, "_start_gap"}, 64'(st - last), 64'd1);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_ram[%0d]", p, k), 64'(m[k]), 64'(expq[k]));
  endtask

  task automatic finish_frame(string p, bit keep_en, int db);
    int c;
    b.iENABLE  = keep_en;
    b.iFFT_RDY = 1'b0;
    step(50);
    chk({p, "_no_done_low"}, 64'(dq.size() - db), 64'd0);
    b.iFFT_RDY = 1'b1;
    c = cyc;
    for (int i = 0; i < 10 && dq.size() == db; i++) @(negedge clk);
    chk({p, "_done_lat"},
        64'((dq.size() > db) ? dq[db] : -1), 64'(c + 1));
    chk({p, "_busy_at_done"},
        64'((dq.size() > db) ? dbz[db] : 1'bx), 64'(CONT && keep_en));
    step(3);
    chk({p, "_done_once"}, 64'(dq.size() - db), 64'd1);
  endtask

  task automatic chk_zero(string p);
    chk({p, "_we"}, 64'({b.oWE_3, b.oWE_2, b.oWE_1, b.oWE_0}), 64'd0);
    chk({p, "_start"}, 64'(b.oSTART), 64'd0);
    chk({p, "_busy"}, 64'(b.oBUSY), 64'd0);
    chk({p, "_done"}, 64'(b.oFRAME_DONE), 64'd0);
    chk({p, "_ovr"}, 64'(b.oOVERRUN), 64'd0);
    chk({p, "_data"}, 64'(b.oDATA), 64'd0);
    chk({p, "_addr0"}, 64'(b.oADDR_WR_0), 64'd0);
    chk({p, "_addr1"}, 64'(b.oADDR_WR_1), 64'd0);
    chk({p, "_addr2"}, 64'(b.oADDR_WR_2), 64'd0);
    chk({p, "_addr3"}, 64'(b.oADDR_WR_3), 64'd0);
  endtask

  initial begin
    int wb;
    int sb;
    int db;
    int c0;
    b.iENABLE    = 1'b0;
    b.iADC_DATA  = '0;
    b.iADC_VALID = 1'b0;
    b.iFFT_RDY   = 1'b0;
    rst          = 1'b1;
    step(3);
    chk_zero("reset");
    rst = 1'b0;

    // samples while IDLE are ignored without flagging overrun
    for (int i = 0; i < 5; i++) begin
      b.iADC_DATA  = (D-1)'($urandom);
      b.iADC_VALID = 1'b1;
      step(1);
    end
    b.iADC_VALID = 1'b0;
    step(2);
    chk("idle_no_we", 64'(wq.size()), 64'd0);
    chk("idle_no_ovr", 64'(b.oOVERRUN), 64'd0);

    // ramp, back to back, RDY already high
    b.iFFT_RDY = 1'b1;
    b.iENABLE  = 1'b1;
    step(1);
    chk("t1_busy", 64'(b.oBUSY), 64'd1);
    wb = wq.size(); sb = sq.size(); db = dq.size();
    expq.delete();
    c0 = cyc;
    feed(N, 0, 1'b0, 0, '0);
    chk("t1_first_lat",
        64'((wq.size() > wb) ? wq[wb].cyc : -1), 64'(c0 + 1));
    wait_start(sb);
    check_frame("t1", wb, sb);
    chk("t1_hold_data", 64'(b.oDATA), 64'(expq[N-1]));
    chk("t1_hold_addr0", 64'(b.oADDR_WR_0), 64'(Q - 1));
    chk("t1_hold_addr3", 64'(b.oADDR_WR_3), 64'(Q - 1));
    step(5);
    chk("t1_stale_rdy", 64'(dq.size() - db), 64'd0);
    chk("t1_busy_wait", 64'(b.oBUSY), 64'd1);
    finish_frame("t1", 1'b0, db);

    // valid every third cycle, constant 100
    b.iENABLE = 1'b1;
    step(1);
    chk("t2_ovr0", 64'(b.oOVERRUN), 64'd0);
    wb = wq.size(); sb = sq.size(); db = dq.size();
    expq.delete();
    feed(N - 1, 2, 1'b0, 1, (D-1)'(100));
    step(3);
    chk("t2_no_early_start", 64'(sq.size() - sb), 64'd0);
    feed(1, 2, 1'b0, 1, (D-1)'(100));
    wait_start(sb);
    check_frame("t2", wb, sb);

    // samples while waiting for the FFT are dropped
    c0 = wq.size();
    for (int i = 0; i < 10; i++) begin
      b.iADC_DATA  = (D-1)'($urandom);
      b.iADC_VALID = 1'b1;
      step(1);
    end
    b.iADC_VALID = 1'b0;
    step(1);
    chk("t4_no_we", 64'(wq.size() - c0), 64'd0);
    chk("t4_ovr_set", 64'(b.oOVERRUN), 64'd1);
    finish_frame("t4", 1'b0, db);
    chk("t4_ovr_sticky", 64'(b.oOVERRUN), 64'd1);

    // abort after 2000 samples, then a clean frame
    b.iENABLE = 1'b1;
    step(1);
    chk("t5_ovr_cleared", 64'(b.oOVERRUN), 64'd0);
    sb = sq.size();
    expq.delete();
    feed(2000, 0, 1'b1, 2, '0);
    b.iENABLE = 1'b0;
    step(2);
    chk("t5_idle", 64'(b.oBUSY), 64'd0);
    step(20);
    chk("t5_no_start", 64'(sq.size() - sb), 64'd0);
    b.iENABLE = 1'b1;
    step(1);
    wb = wq.size(); sb = sq.size(); db = dq.size();
    expq.delete();
    feed(N, 0, 1'b1, 2, '0);
    chk("t5_first_bank",
        64'((wq.size() > wb) ? wq[wb].bank : -1), 64'd0);
    chk("t5_first_addr",
        64'((wq.size() > wb) ? wq[wb].addr : -1), 64'd0);
    wait_start(sb);
    check_frame("t5", wb, sb);
    finish_frame("t5", 1'b0, db);

    // reset at cnt=3000 together with a valid sample
    b.iENABLE = 1'b1;
    step(1);
    wb = wq.size(); sb = sq.size();
    expq.delete();
    feed(3000, 0, 1'b0, 2, '0);
    rst          = 1'b1;
    b.iADC_DATA  = (D-1)'($urandom);
    b.iADC_VALID = 1'b1;
    step(1);
    chk_zero("t6a");
    rst          = 1'b0;
    b.iADC_VALID = 1'b0;
    b.iENABLE    = 1'b0;
    step(10);
    chk("t6a_writes", 64'(wq.size() - wb), 64'd3000);
    chk("t6a_no_start", 64'(sq.size() - sb), 64'd0);

    // reset in the LAUNCH cycle
    b.iENABLE = 1'b1;
    step(1);
    wb = wq.size(); sb = sq.size();
    expq.delete();
    feed(N, 0, 1'b0, 2, '0);
    rst = 1'b1;
    step(1);
    chk_zero("t6b");
    rst       = 1'b0;
    b.iENABLE = 1'b0;
    step(10);
    chk("t6b_writes", 64'(wq.size() - wb), 64'(N));
    chk("t6b_no_start", 64'(sq.size() - sb), 64'd0);

    // two frames with iENABLE held high
    b.iENABLE = 1'b1;
    step(1);
    for (int f = 0; f < 2; f++) begin
      wb = wq.size(); sb = sq.size(); db = dq.size();
      expq.delete();
      feed(N, 0, 1'b0, 2, '0);
      wait_start(sb);
      check_frame($sformatf("t7f%0d", f), wb, sb);
      finish_frame($sformatf("t7f%0d", f), (f == 0), db);
    end

    chk("single_we", 64'(multi), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
